shift_req_buf: RTL and testbench
================================

SHIFT_REQ_BUF -- requirements
Module: shift_req_buf

Interface
REQ-001 Parameter DATA_LEN, default 8: operand and result width in bits.
REQ-002 Parameter DEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-003 Derived constant SHAMT_W = clog2(DATA_LEN), which is 3 at the default.
REQ-004 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-007 Request payload inputs: req_din (DATA_LEN), req_shamt (SHAMT_W), req_left (1), req_arith (1).
REQ-008 Shifter drive outputs: sh_din (DATA_LEN), sh_shamt (SHAMT_W), sh_left (1), sh_arith (1).
REQ-009 Port sh_dout, input, DATA_LEN: combinational result returned from barrel_shifter.
REQ-010 Ports res_valid (output, 1), res_ready (input, 1) and res_data (output, DATA_LEN): result handshake.
REQ-011 Port done_cnt, output, 16 bits: present only when the Configuration macro is defined.

Function
REQ-012 A request is accepted on a cycle with req_valid and req_ready both high; its payload is written at the FIFO tail.
REQ-013 req_ready = !full; it depends only on the registered count and never on a same-cycle pop.
REQ-014 The sh_* outputs show the FIFO head entry every cycle; when the FIFO is empty they are driven to zero.
REQ-015 Pop condition: FIFO not empty and (!res_valid or res_ready).
REQ-016 On a pop, res_data <= sh_dout and res_valid <= 1.
REQ-017 If res_valid and res_ready are high and no pop occurs, res_valid <= 0.
REQ-018 Latency: a request accepted in cycle N, with the FIFO empty and the output stage free, gives res_valid high in cycle N+2.
REQ-019 Throughput is one result per cycle while res_ready stays high.
REQ-020 While res_valid=1 and res_ready=0, res_data holds stable.
REQ-021 Push and pop in the same cycle leave the count unchanged and are legal at any non-full, non-empty occupancy.
REQ-022 When the FIFO is empty, a push and a pop cannot occur in the same cycle; the entry is not visible until the next cycle.
REQ-023 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 count ranges 0..DEPTH; full is count==DEPTH and empty is count==0.
REQ-025 Results leave strictly in acceptance order; no request is dropped or duplicated.

Reset
REQ-026 When rst=1 at a clock edge: count, both pointers and res_valid <= 0, and res_data <= 0.
REQ-027 Reset during operation discards all queued entries and any pending result.
REQ-028 While rst=1, req_ready=0.
REQ-029 FIFO storage contents are not reset.

Configuration
REQ-030 Macro SHIFT_REQ_BUF_DONE_CNT_EN controls the done_cnt feature.
REQ-031 With the macro defined, done_cnt increments on each res_valid&&res_ready cycle, saturates at 16'hFFFF and is cleared by rst.
REQ-032 Without the macro, the done_cnt port and its counter do not exist; all other behaviour is identical.

Structure
REQ-033 A shared package holds the DATA_LEN default, the SHAMT_W derivation and a packed request struct {din, shamt, left, arith}.
REQ-034 One sub-module, shift_req_fifo, holds the storage, the pointers and the count.
REQ-035 shift_req_buf contains the output register stage and the optional counter.
REQ-036 barrel_shifter is instantiated next to this block by the parent, not inside it.

Verification
REQ-037 Reset, then a single request din=8'hB4, shamt=2, left=0, arith=1 -> res_valid in cycle N+2 with res_data=8'hED.
REQ-038 Back-to-back requests with res_ready=1: {8'h81, shamt 1, left} then {8'hB4, shamt 2, logical right} -> 8'h02 then 8'h2D on consecutive cycles.
REQ-039 res_ready=0 with continuous requests -> exactly DEPTH+1 = 5 accepted; req_ready low thereafter; raising res_ready drains 5 results in order.
REQ-040 Full FIFO with res_ready toggling each cycle -> req_ready low until the first pop, no lost or duplicated data, and the pointers wrap correctly over 3 or more fills.
REQ-041 rst asserted with 3 entries queued and res_valid=1 -> the next cycle shows res_valid=0 and req_ready=1 after rst falls, and no stale result appears.
REQ-042 With SHIFT_REQ_BUF_DONE_CNT_EN defined: 10 completed transfers -> done_cnt=10; after rst -> done_cnt=0.

Source files
------------

// File: rtl/shift_req_buf_pkg.sv
// Shared types and width helpers for the shift request buffer.
// The request word layout {din, shamt, left, arith} is fixed here.
package shift_req_buf_pkg;

  localparam int DATA_LEN_DEF = 8;
  localparam int DEPTH_DEF    = 4;

  function automatic int shamt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  function automatic int req_width(input int len);
    return len + shamt_width(len) + 2;
  endfunction

  localparam int SHAMT_W_DEF = shamt_width(DATA_LEN_DEF);

  typedef struct packed {
    logic [DATA_LEN_DEF-1:0] din;
    logic [SHAMT_W_DEF-1:0]  shamt;
    logic                    left;
    logic                    arith;
  } req_t;

endpackage

// File: rtl/shift_req_fifo.sv
// Request FIFO: storage, wrapping pointers and occupancy count.
// Storage is deliberately left out of reset; only pointers and count clear.
module shift_req_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  // Guard locally so a misbehaving caller cannot corrupt the count.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_req_buf.sv
// Request buffer in front of an external barrel_shifter, with a registered result stage.
// Define SHIFT_REQ_BUF_DONE_CNT_EN to add the saturating done_cnt output.
module shift_req_buf
  import shift_req_buf_pkg::*;
#(
  parameter  int DATA_LEN = DATA_LEN_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  localparam int SHAMT_W  = shamt_width(DATA_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_din,
  input  logic [SHAMT_W-1:0]  req_shamt,
  input  logic                req_left,
  input  logic                req_arith,
  output logic [DATA_LEN-1:0] sh_din,
  output logic [SHAMT_W-1:0]  sh_shamt,
  output logic                sh_left,
  output logic                sh_arith,
  input  logic [DATA_LEN-1:0] sh_dout,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_LEN-1:0] res_data
`ifdef SHIFT_REQ_BUF_DONE_CNT_EN
  ,
  output logic [15:0]         done_cnt
`endif
);

  localparam int REQ_W = req_width(DATA_LEN);

  logic [REQ_W-1:0]    wdata, head;
  logic                full, empty, push, pop;
  logic                res_valid_q, res_valid_d;
  logic [DATA_LEN-1:0] res_data_q, res_data_d;

  // req_ready comes from registered occupancy only, never from this cycle's pop.
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = !empty && (!res_valid_q || res_ready);
  assign wdata     = {req_din, req_shamt, req_left, req_arith};

  shift_req_fifo #(
    .W     (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    {sh_din, sh_shamt, sh_left, sh_arith} = '0;
    if (!empty) {sh_din, sh_shamt, sh_left, sh_arith} = head;
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (pop) begin
      res_valid_d = 1'b1;
      res_data_d  = sh_dout;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

`ifdef SHIFT_REQ_BUF_DONE_CNT_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (res_valid_q && res_ready && (done_cnt_q != 16'hFFFF))
      done_cnt_d = done_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) done_cnt_q <= '0;
    else     done_cnt_q <= done_cnt_d;
  end

  assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_shift_req_buf.sv
// Directed self-checking bench for shift_req_buf; models the external barrel_shifter.
// Exercises done_cnt when SHIFT_REQ_BUF_DONE_CNT_EN is defined.
module tb_shift_req_buf;
  import shift_req_buf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [7:0] req_din;
  logic [2:0] req_shamt;
  logic       req_left, req_arith;
  logic [7:0] sh_din;
  logic [2:0] sh_shamt;
  logic       sh_left, sh_arith;
  logic [7:0] sh_dout;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
`ifdef SHIFT_REQ_BUF_DONE_CNT_EN
  logic [15:0] done_cnt;
`endif

  int checks;
  int errors;
  logic [7:0] expq [$];

  always #5 clk = ~clk;

  shift_req_buf dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din   (req_din),
    .req_shamt (req_shamt),
    .req_left  (req_left),
    .req_arith (req_arith),
    .sh_din    (sh_din),
    .sh_shamt  (sh_shamt),
    .sh_left   (sh_left),
    .sh_arith  (sh_arith),
    .sh_dout   (sh_dout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
`ifdef SHIFT_REQ_BUF_DONE_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  function automatic logic [7:0] shiftModel(input logic [7:0] d, input logic [2:0] s,
                                            input logic l, input logic a);
    logic [7:0] r;
    if (l)      r = d << s;
    else if (a) r = 8'($signed(d) >>> s);
    else        r = d >> s;
    return r;
  endfunction

  // Stand-in for the parent's combinational barrel_shifter.
  always_comb sh_dout = shiftModel(sh_din, sh_shamt, sh_left, sh_arith);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] s,
                               input logic l, input logic a);
    req_valid = v;
    req_din   = d;
    req_shamt = s;
    req_left  = l;
    req_arith = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    res_ready = 1'b0;
    applyStimulus(1'b1, 8'hFF, 3'd1, 1'b0, 1'b0);
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_res_data: got %h expected 00", res_data); end
    checks++; if (sh_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_sh_din: got %h expected 00", sh_din); end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_req_ready: got %b expected 1", req_ready); end
    tick();
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    applyStimulus(1'b1, 8'hB4, 3'd2, 1'b0, 1'b1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_accept: got %b expected 1", req_ready); end
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_n1_valid: got %b expected 0", res_valid); end
    checks++; if ({sh_din, sh_shamt, sh_left, sh_arith} !== {8'hB4, 3'd2, 1'b0, 1'b1}) begin
      errors++; $display("[TB] FAIL single_sh_drive: got %h/%0d/%b/%b expected B4/2/0/1", sh_din, sh_shamt, sh_left, sh_arith);
    end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_n2_valid: got %b expected 1", res_valid); end
    checks++; if (res_data !== 8'hED) begin errors++; $display("[TB] FAIL single_n2_data: got %h expected ED", res_data); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_consumed: got %b expected 0", res_valid); end
    checks++; if (sh_din !== 8'h00) begin errors++; $display("[TB] FAIL single_empty_sh: got %h expected 00", sh_din); end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    applyStimulus(1'b1, 8'h81, 3'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hB4, 3'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    checks++; if ({res_valid, res_data} !== {1'b1, 8'h02}) begin
      errors++; $display("[TB] FAIL b2b_first: got valid=%b data=%h expected valid=1 data=02", res_valid, res_data);
    end
    tick();
    checks++; if ({res_valid, res_data} !== {1'b1, 8'h2D}) begin
      errors++; $display("[TB] FAIL b2b_second: got valid=%b data=%h expected valid=1 data=2D", res_valid, res_data);
    end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 0", res_valid); end
  endtask

  task automatic test_fill_drain();
    logic expReady;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 3'd0, 1'b0, 1'b0);
      expReady = (i < 5);
      checks++; if (req_ready !== expReady) begin
        errors++; $display("[TB] FAIL fill_req_ready[%0d]: got %b expected %b", i, req_ready, expReady);
      end
      if (i >= 2) begin
        checks++; if ({res_valid, res_data} !== {1'b1, 8'h10}) begin
          errors++; $display("[TB] FAIL fill_hold[%0d]: got valid=%b data=%h expected valid=1 data=10", i, res_valid, res_data);
        end
      end
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({res_valid, res_data} !== {1'b1, 8'(8'h10 + k)}) begin
        errors++; $display("[TB] FAIL drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, res_valid, res_data, 8'(8'h10 + k));
      end
      tick();
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_done: got %b expected 0", res_valid); end
  endtask

  task automatic test_wrap_toggle();
    int n = 0;
    int got = 0;
    logic [7:0] d, exp;
    logic [2:0] s;
    logic l, a;
    expq.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 8'(8'h5A ^ (n * 37)); s = 3'(n); l = (n % 2) == 1; a = ((n / 2) % 2) == 1;
      applyStimulus(1'b1, d, s, l, a);
      if (req_ready) begin expq.push_back(shiftModel(d, s, l, a)); n++; end
      tick();
    end
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL wrap_fill_count: got %0d expected 5", n); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL wrap_full_ready: got %b expected 0", req_ready); end
    for (int i = 0; i < 40; i++) begin
      res_ready = (i % 2) == 0;
      d = 8'(8'h5A ^ (n * 37)); s = 3'(n); l = (n % 2) == 1; a = ((n / 2) % 2) == 1;
      applyStimulus(1'b1, d, s, l, a);
      if (req_ready) begin expq.push_back(shiftModel(d, s, l, a)); n++; end
      if (res_valid && res_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("[TB] FAIL wrap_extra_result: got %h expected none", res_data);
        end else begin
          exp = expq.pop_front();
          got++;
          if (res_data !== exp) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", got, res_data, exp); end
        end
      end
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    res_ready = 1'b1;
    for (int i = 0; i < 20 && expq.size() > 0; i++) begin
      if (res_valid) begin
        exp = expq.pop_front();
        got++;
        checks++; if (res_data !== exp) begin errors++; $display("[TB] FAIL wrap_drain[%0d]: got %h expected %h", got, res_data, exp); end
      end
      tick();
    end
    checks++; if (got != n) begin errors++; $display("[TB] FAIL wrap_total: got %0d results expected %0d", got, n); end
    checks++; if (n < 13) begin errors++; $display("[TB] FAIL wrap_fills: got %0d accepted expected at least 13", n); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle: got %b expected 0", res_valid); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'hC0 + i), 3'd1, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pending: got %b expected 1", res_valid); end
    rst = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b expected 0", res_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready_in_rst: got %b expected 0", req_ready); end
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready_after: got %b expected 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({res_valid, sh_din} !== {1'b0, 8'h00}) begin
        errors++; $display("[TB] FAIL rstmid_stale[%0d]: got valid=%b sh_din=%h expected valid=0 sh_din=00", i, res_valid, sh_din);
      end
    end
  endtask

`ifdef SHIFT_REQ_BUF_DONE_CNT_EN
  task automatic test_done_cnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(i), 3'd0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (4) tick();
    checks++; if (done_cnt !== 16'd10) begin errors++; $display("[TB] FAIL done_cnt_ten: got %0d expected 10", done_cnt); end
    rst = 1'b1;
    tick();
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("[TB] FAIL done_cnt_reset: got %0d expected 0", done_cnt); end
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    res_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_drain();
    test_wrap_toggle();
    test_reset_mid();
`ifdef SHIFT_REQ_BUF_DONE_CNT_EN
    test_done_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
